// File: rtl/binary_counter_mod.sv
// Parametrised binary up/down counter with synchronous load, modulus, wrap/saturate/one-shot
// modes, terminal-count/cascade outputs and a registered compare-match flag.
module binary_counter_mod #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ceo,
  output logic             match,
  output logic             done
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;

  state_t           state, state_nx;
  logic [WIDTH-1:0] count_nx;
  logic             done_nx;

  // Up-terminal uses >= so a loaded value above modulus is treated as the boundary.
  assign tc  = dir ? (count >= modulus) : (count == '0);
  assign ceo = tc & en & ~load & (state == RUN);

  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = done;
    if (load) begin
      count_nx = load_data;
      state_nx = RUN;
      done_nx  = 1'b0;
    end else if (en && state == RUN) begin
      if (!tc) begin
        count_nx = dir ? count + 1'b1 : count - 1'b1;
      end else begin
        unique case (mode)
          MODE_SAT: count_nx = dir ? modulus : count;
          MODE_ONE: begin
            state_nx = HALT;
            done_nx  = 1'b1;
          end
          default:  count_nx = dir ? '0 : modulus;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_VALUE;
      state <= RUN;
      done  <= 1'b0;
      match <= 1'b0;
    end else begin
      count <= count_nx;
      state <= state_nx;
      done  <= done_nx;
      match <= (count == cmp_val);
    end
  end

endmodule

// File: tb/tb_binary_counter_mod.sv
// Directed bench for binary_counter_mod: two 4-bit instances cascaded via ceo, expected
// outputs queued per cycle by the driver and checked by an independent negedge monitor.
module tb_binary_counter_mod;

  logic       clk = 1'b0;
  logic       rst, en, dir, load;
  logic [3:0] load_data, modulus, cmp_val;
  logic [1:0] mode;
  logic [3:0] count0, count1;
  logic       tc0, ceo0, match0, done0;
  logic       tc1, ceo1, match1, done1;

  always #5 clk = ~clk;

  binary_counter_mod #(.WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_data(load_data),
    .mode(mode), .modulus(modulus), .cmp_val(cmp_val),
    .count(count0), .tc(tc0), .ceo(ceo0), .match(match0), .done(done0)
  );

  binary_counter_mod #(.WIDTH(4)) dut1 (
    .clk(clk), .rst(rst), .en(ceo0), .dir(1'b1), .load(1'b0), .load_data(4'd0),
    .mode(2'b00), .modulus(4'd15), .cmp_val(4'd0),
    .count(count1), .tc(tc1), .ceo(ceo1), .match(match1), .done(done1)
  );

  typedef struct {
    string nm;
    int    c0;
    int    c1;
    bit    tc;
    bit    ceo;
    bit    m;
    bit    d;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit   bad;
      e   = q.pop_front();
      bad = 1'b0;
      n_vec++;
      if (int'(count0) != e.c0 || tc0 != e.tc || ceo0 != e.ceo || match0 != e.m || done0 != e.d) begin
        $display("FAIL %s: got count=%0d tc=%0b ceo=%0b match=%0b done=%0b, want count=%0d tc=%0b ceo=%0b match=%0b done=%0b",
                 e.nm, count0, tc0, ceo0, match0, done0, e.c0, e.tc, e.ceo, e.m, e.d);
        bad = 1'b1;
      end
      if (e.c1 >= 0 && int'(count1) != e.c1) begin
        $display("FAIL %s: got count1=%0d, want count1=%0d", e.nm, count1, e.c1);
        bad = 1'b1;
      end
      if (bad) n_bad++;
    end
  end

  // Queue what the outputs must show this cycle, then advance one clock.
  task automatic cyc(input string nm, input int c, input bit t, input bit ce,
                     input bit m, input bit d, input int c1 = -1);
    exp_t e;
    e.nm = nm; e.c0 = c; e.c1 = c1; e.tc = t; e.ceo = ce; e.m = m; e.d = d;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_data = 4'd0;
    mode = 2'b00; modulus = 4'd9; cmp_val = 4'd7;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("reset", 0, 0, 0, 0, 0, 0);

    // wrap up through modulus 9
    en = 1'b1;
    for (int i = 0; i < 12; i++)
      cyc("wrap_up", i % 10, (i % 10) == 9, (i % 10) == 9, i > 0 && ((i - 1) % 10) == 7, 0);

    // wrap down from a loaded 2
    load = 1'b1; load_data = 4'd2; dir = 1'b0; en = 1'b0;
    cyc("load2", 2, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    cyc("wrap_dn", 2, 0, 0, 0, 0);
    cyc("wrap_dn", 1, 0, 0, 0, 0);
    cyc("wrap_dn", 0, 1, 1, 0, 0);
    cyc("wrap_dn", 9, 0, 0, 0, 0);
    cyc("wrap_dn", 8, 0, 0, 0, 0);
    en = 1'b0;
    cyc("match_lag", 7, 0, 0, 0, 0);
    cyc("match_hi", 7, 0, 0, 1, 0);

    // saturate; load beats en, out-of-range load clamps
    mode = 2'b01; modulus = 4'd5; dir = 1'b1; load = 1'b1; load_data = 4'd0; en = 1'b1;
    cyc("load_wins", 7, 1, 0, 1, 0);
    load = 1'b0;
    for (int i = 0; i < 8; i++)
      cyc("sat_up", (i < 5) ? i : 5, i >= 5, i >= 5, i == 0, 0);
    load = 1'b1; load_data = 4'd12; en = 1'b0;
    cyc("sat_ld12", 5, 1, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    cyc("sat_oor", 12, 1, 1, 0, 0);
    cyc("sat_clamp", 5, 1, 1, 0, 0);
    load = 1'b1; load_data = 4'd1; en = 1'b0;
    cyc("sat_ld1", 5, 1, 0, 0, 0);
    load = 1'b0; dir = 1'b0; en = 1'b1;
    cyc("sat_dn", 1, 0, 0, 0, 0);
    cyc("sat_dn", 0, 1, 1, 0, 0);
    cyc("sat_dn", 0, 1, 1, 0, 0);

    // one-shot: halt, ignore mode change, resume only via load
    mode = 2'b10; modulus = 4'd3; dir = 1'b1;
    cyc("os_up", 0, 0, 0, 0, 0);
    cyc("os_up", 1, 0, 0, 0, 0);
    cyc("os_up", 2, 0, 0, 0, 0);
    cyc("os_up", 3, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) mode = 2'b00;
      cyc("os_halt", 3, 1, 0, 0, 1);
    end
    load = 1'b1; load_data = 4'd0; en = 1'b0; mode = 2'b10;
    cyc("os_load", 3, 1, 0, 0, 1);
    load = 1'b0; en = 1'b1;
    cyc("os_resume", 0, 0, 0, 0, 0);
    cyc("os_resume", 1, 0, 0, 0, 0);
    cyc("os_resume", 2, 0, 0, 0, 0);
    cyc("os_resume", 3, 1, 1, 0, 0);

    // reset in HALT with load asserted
    rst = 1'b1; load = 1'b1; load_data = 4'd5;
    cyc("rst_halt", 3, 1, 0, 0, 1);
    rst = 1'b0; load = 1'b0; en = 1'b0; mode = 2'b00; modulus = 4'd15;
    cyc("post_rst", 0, 0, 0, 0, 0, 0);

    // 8-bit cascade of two 4-bit stages
    en = 1'b1;
    for (int i = 0; i <= 256; i++)
      cyc("cascade", i % 16, (i % 16) == 15, (i % 16) == 15,
          i > 0 && ((i - 1) % 16) == 7, 0, (i / 16) % 16);

    // modulus 0 in wrap mode pins the count at 0
    modulus = 4'd0;
    cyc("mod0", 1, 1, 1, 0, 0);
    cyc("mod0", 0, 1, 1, 0, 0);
    cyc("mod0", 0, 1, 1, 0, 0);

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      n_bad++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
